// File: rtl/serial_frame_if.sv
// Bit-strobe input and frame-status output bundle shared by serial_frame_ctrl and its client.
interface serial_frame_if #(
  parameter int LEN_W = 4
);
  logic             step_en;
  logic             ser_in;
  logic             ser_out;
  logic             ser_out_valid;
  logic             cnt_inc;
  logic             cnt_rst;
  logic             frame_done;
  logic             frame_err;
  logic             busy;
  logic [LEN_W-1:0] rem_cnt;

  modport master (
    output step_en, ser_in,
    input  ser_out, ser_out_valid, cnt_inc, cnt_rst, frame_done, frame_err, busy, rem_cnt
  );

  modport slave (
    input  step_en, ser_in,
    output ser_out, ser_out_valid, cnt_inc, cnt_rst, frame_done, frame_err, busy, rem_cnt
  );
endinterface

// File: rtl/serial_frame_ctrl.sv
// Step-driven frame sequencer: header hunt, length field, payload pass-through, decade counter control.
// Optional macro FRAME_TIMEOUT_EN adds an idle-clock abort while in LEN/DATA.
module serial_frame_ctrl #(
  parameter int               HDR_W       = 3,
  parameter logic [HDR_W-1:0] HEADER      = 3'b101,
  parameter int               LEN_W       = 4,
  parameter int               MAX_LEN     = 9,
  parameter int               TIMEOUT_CYC = 50_000_000
) (
  input  logic         clk,
  input  logic         rst,
  serial_frame_if.slave sf
);

  localparam int               IDX_W    = $clog2(LEN_W + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN_W - 1);
  localparam logic [LEN_W-1:0] MAX_L    = LEN_W'(MAX_LEN);

  if (MAX_LEN >= (1 << LEN_W) || MAX_LEN < 1 || TIMEOUT_CYC < 2) begin : g_param_chk
    $error("serial_frame_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_LEN, S_DATA, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [HDR_W-1:0] window, window_nxt, window_sh;
  logic [LEN_W-1:0] len_sr, len_nxt, len_sh;
  logic [LEN_W-1:0] rem, rem_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             ser_out_q, ser_out_nxt;
  logic             valid_q, valid_nxt;
  logic             inc_q, inc_nxt;
  logic             crst_q, crst_nxt;
  logic             done_q, done_nxt;
  logic             err_q, err_nxt;
  logic             busy_q, busy_nxt;

`ifdef FRAME_TIMEOUT_EN
  localparam int               TMO_W   = $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] tmo, tmo_nxt;
`endif

  assign window_sh = {window[HDR_W-2:0], sf.ser_in};
  assign len_sh    = {len_sr[LEN_W-2:0], sf.ser_in};

  always_comb begin
    state_nxt   = state;
    window_nxt  = window;
    len_nxt     = len_sr;
    idx_nxt     = idx;
    rem_nxt     = rem;
    ser_out_nxt = ser_out_q;
    valid_nxt   = 1'b0;
    inc_nxt     = 1'b0;
    crst_nxt    = 1'b0;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
`ifdef FRAME_TIMEOUT_EN
    tmo_nxt     = '0;
`endif

    case (state)
      S_IDLE: begin
        if (sf.step_en) begin
          window_nxt = window_sh;
          if (window_sh == HEADER) begin
            state_nxt = S_LEN;
            crst_nxt  = 1'b1;
            len_nxt   = '0;
            idx_nxt   = '0;
          end
        end
      end
      S_LEN: begin
        if (sf.step_en) begin
          len_nxt = len_sh;
          idx_nxt = idx + 1'b1;
          if (idx == LAST_IDX) begin
            if (len_sh == '0) begin
              state_nxt = S_DONE;
              done_nxt  = 1'b1;
            end else if (len_sh > MAX_L) begin
              // Stale header bits must not seed the next hunt.
              state_nxt  = S_IDLE;
              err_nxt    = 1'b1;
              window_nxt = '0;
            end else begin
              state_nxt = S_DATA;
              rem_nxt   = len_sh;
            end
          end
        end
      end
      S_DATA: begin
        if (sf.step_en) begin
          ser_out_nxt = sf.ser_in;
          valid_nxt   = 1'b1;
          inc_nxt     = 1'b1;
          rem_nxt     = rem - 1'b1;
          if (rem == LEN_W'(1)) begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
          end
        end
      end
      S_DONE: begin
        // Any step landing here is intentionally discarded.
        window_nxt = '0;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

`ifdef FRAME_TIMEOUT_EN
    if ((state == S_LEN || state == S_DATA) && !sf.step_en) begin
      if (tmo == TMO_MAX) begin
        state_nxt  = S_IDLE;
        err_nxt    = 1'b1;
        window_nxt = '0;
        rem_nxt    = '0;
      end else begin
        tmo_nxt = tmo + 1'b1;
      end
    end
`endif

    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      window    <= '0;
      len_sr    <= '0;
      idx       <= '0;
      rem       <= '0;
      ser_out_q <= 1'b0;
      valid_q   <= 1'b0;
      inc_q     <= 1'b0;
      crst_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      window    <= window_nxt;
      len_sr    <= len_nxt;
      idx       <= idx_nxt;
      rem       <= rem_nxt;
      ser_out_q <= ser_out_nxt;
      valid_q   <= valid_nxt;
      inc_q     <= inc_nxt;
      crst_q    <= crst_nxt;
      done_q    <= done_nxt;
      err_q     <= err_nxt;
      busy_q    <= busy_nxt;
    end
  end

`ifdef FRAME_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tmo <= '0;
    else      tmo <= tmo_nxt;
  end
`endif

  assign sf.ser_out       = ser_out_q;
  assign sf.ser_out_valid = valid_q;
  assign sf.cnt_inc       = inc_q;
  assign sf.cnt_rst       = crst_q;
  assign sf.frame_done    = done_q;
  assign sf.frame_err     = err_q;
  assign sf.busy          = busy_q;
  assign sf.rem_cnt       = rem;

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Bench for serial_frame_ctrl: directed frames plus random steps against a bit-stream parser model.
module tb_serial_frame_ctrl;

  localparam int         HDR_W   = 3;
  localparam logic [2:0] HEADER  = 3'b101;
  localparam int         LEN_W   = 4;
  localparam int         MAX_LEN = 9;
`ifdef FRAME_TIMEOUT_EN
  localparam int TMO    = 20;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TMO    = 50_000_000;
  localparam bit TMO_EN = 1'b0;
`endif
  localparam int HUNT = 0, LEN = 1, DATA = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_frame_if #(.LEN_W(LEN_W)) sf ();

  serial_frame_ctrl #(
    .HDR_W(HDR_W), .HEADER(HEADER), .LEN_W(LEN_W), .MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sf (sf)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state: a parser over the stream of accepted bits.
  int m_hist[$];
  int m_mode, m_len, m_lcnt, m_rem, m_idle;
  bit m_in_done, m_sout;
  bit e_valid, e_inc, e_crst, e_done, e_err;

  // Observation counters for scenario-level checks.
  int n_inc, n_valid, n_crst, n_done, n_err;
  logic [31:0] data_bits;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] obs();
    return {sf.ser_out, sf.ser_out_valid, sf.cnt_inc, sf.cnt_rst, sf.frame_done,
            sf.frame_err, sf.busy, sf.rem_cnt};
  endfunction

  function automatic logic [10:0] expv();
    bit busy;
    busy = (m_mode != HUNT) || m_in_done;
    return {m_sout, e_valid, e_inc, e_crst, e_done, e_err, busy, 4'(m_rem)};
  endfunction

  function automatic void clear_hist();
    m_hist.delete();
    repeat (HDR_W) m_hist.push_back(0);
  endfunction

  function automatic int hist_val();
    int v = 0;
    foreach (m_hist[i]) v = v * 2 + m_hist[i];
    return v;
  endfunction

  function automatic void model_reset();
    clear_hist();
    m_mode = HUNT; m_len = 0; m_lcnt = 0; m_rem = 0; m_idle = 0;
    m_in_done = 0; m_sout = 0;
    e_valid = 0; e_inc = 0; e_crst = 0; e_done = 0; e_err = 0;
  endfunction

  function automatic void finish_frame();
    e_done    = 1;
    m_in_done = 1;
    m_mode    = HUNT;
  endfunction

  function automatic void model_step(input bit se, input bit b);
    e_valid = 0; e_inc = 0; e_crst = 0; e_done = 0; e_err = 0;
    if (m_in_done) begin
      m_in_done = 0;
      clear_hist();
    end else if (m_mode == HUNT) begin
      if (se) begin
        m_hist.push_back(int'(b));
        void'(m_hist.pop_front());
        if (hist_val() == int'(HEADER)) begin
          m_mode = LEN; e_crst = 1; m_len = 0; m_lcnt = 0; m_idle = 0;
        end
      end
    end else if (se) begin
      m_idle = 0;
      if (m_mode == LEN) begin
        m_len = m_len * 2 + int'(b);
        m_lcnt++;
        if (m_lcnt == LEN_W) begin
          if (m_len == 0) finish_frame();
          else if (m_len > MAX_LEN) begin
            e_err = 1; m_mode = HUNT; clear_hist();
          end else begin
            m_rem = m_len; m_mode = DATA;
          end
        end
      end else begin
        m_sout = b; e_valid = 1; e_inc = 1;
        m_rem--;
        if (m_rem == 0) finish_frame();
      end
    end else begin
      m_idle++;
      if (TMO_EN && m_idle == TMO) begin
        e_err = 1; m_mode = HUNT; m_rem = 0; m_idle = 0; clear_hist();
      end
    end
  endfunction

  function automatic void clr_counts();
    n_inc = 0; n_valid = 0; n_crst = 0; n_done = 0; n_err = 0; data_bits = '0;
  endfunction

  task automatic tick(input bit se, input bit b);
    @(negedge clk);
    sf.step_en = se;
    sf.ser_in  = b;
    @(posedge clk);
    model_step(se, b);
    #1;
    chk("cycle", 32'(obs()), 32'(expv()));
    n_inc   += int'(sf.cnt_inc);
    n_valid += int'(sf.ser_out_valid);
    n_crst  += int'(sf.cnt_rst);
    n_done  += int'(sf.frame_done);
    n_err   += int'(sf.frame_err);
    if (sf.ser_out_valid) data_bits = {data_bits[30:0], sf.ser_out};
  endtask

  task automatic send(input logic [31:0] v, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      tick(1'b1, v[i]);
      repeat (gap) tick(1'b0, 1'b0);
    end
  endtask

  task automatic do_reset(input bit with_step);
    @(negedge clk);
    sf.step_en = with_step;
    sf.ser_in  = 1'b1;
    rst = 1'b0;
    #1;
    model_reset();
    chk("reset_state", 32'(obs()), 32'(expv()));
    @(posedge clk);
    #1;
    chk("reset_hold", 32'(obs()), 32'(expv()));
    @(negedge clk);
    rst = 1'b1;
    sf.step_en = 1'b0;
  endtask

  initial begin
    sf.step_en = 1'b0;
    sf.ser_in  = 1'b0;
    model_reset();
    do_reset(1'b0);

    // Good frame: header, length 3, payload 101.
    clr_counts();
    send(32'b101, 3, 0); send(32'b0011, 4, 0); send(32'b101, 3, 0);
    repeat (3) tick(1'b0, 1'b0);
    chk("good_inc", n_inc, 3);
    chk("good_valid", n_valid, 3);
    chk("good_data", data_bits, 32'b101);
    chk("good_done", n_done, 1);
    chk("good_crst", n_crst, 1);
    chk("good_idle", 32'(sf.busy), 0);

    // Empty frame.
    clr_counts();
    send(32'b101, 3, 0); send(32'b0000, 4, 0);
    repeat (2) tick(1'b0, 1'b0);
    chk("empty_done", n_done, 1);
    chk("empty_inc", n_inc, 0);
    chk("empty_idle", 32'(sf.busy), 0);

    // Illegal length 10.
    clr_counts();
    send(32'b101, 3, 0); send(32'b1010, 4, 0);
    repeat (2) tick(1'b0, 1'b0);
    chk("illegal_err", n_err, 1);
    chk("illegal_valid", n_valid, 0);
    chk("illegal_idle", 32'(sf.busy), 0);

    // Overlapping header with long gaps; bits 4-5 start the length field (0100 = 4).
    clr_counts();
    send(32'b10101, 5, 100); send(32'b00, 2, 0); send(32'b1100, 4, 0);
    repeat (2) tick(1'b0, 1'b0);
    chk("overlap_crst", n_crst, 1);
    chk("overlap_inc", n_inc, 4);
    chk("overlap_data", data_bits, 32'b1100);
    chk("overlap_done", n_done, 1);

    // Reset in the middle of the payload, then a clean frame.
    clr_counts();
    send(32'b101, 3, 0); send(32'b0101, 4, 0); send(32'b11, 2, 0);
    do_reset(1'b0);
    chk("midrst_done", n_done, 0);
    chk("midrst_err", n_err, 0);
    chk("midrst_rem", 32'(sf.rem_cnt), 0);
    clr_counts();
    send(32'b101, 3, 0); send(32'b0010, 4, 0); send(32'b10, 2, 1);
    repeat (2) tick(1'b0, 1'b0);
    chk("after_rst_inc", n_inc, 2);
    chk("after_rst_data", data_bits, 32'b10);
    chk("after_rst_done", n_done, 1);

    // A step in the DONE cycle must not reach the header window.
    clr_counts();
    send(32'b101, 3, 0); send(32'b0001, 4, 0); send(32'b0, 1, 0);
    tick(1'b1, 1'b1);
    send(32'b01, 2, 0);
    tick(1'b0, 1'b0);
    chk("drop_crst", n_crst, 1);
    chk("drop_idle", 32'(sf.busy), 0);

    // Reset asserted together with a step.
    do_reset(1'b1);

    // Stall in DATA.
    clr_counts();
    send(32'b101, 3, 0); send(32'b0011, 4, 0); send(32'b1, 1, 0);
    repeat (25) tick(1'b0, 1'b0);
`ifdef FRAME_TIMEOUT_EN
    chk("stall_err", n_err, 1);
    chk("stall_busy", 32'(sf.busy), 0);
`else
    chk("stall_err", n_err, 0);
    chk("stall_busy", 32'(sf.busy), 1);
`endif
    do_reset(1'b0);

    // Random stepping.
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 799) == 0) do_reset(1'($urandom_range(0, 1)));
      else tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
